// File: rtl/mem_wb.sv
// mem_wb: MEM/WB pipeline register with load extraction/extension and the LL/SC link bit.
module mem_wb #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_wreg_en,
    input  logic [4:0]  mem_wreg_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_load_op,
    input  logic [1:0]  mem_addr_lo,
    input  logic [31:0] mem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        llbit_clear,
    output logic        wb_wreg_en,
    output logic [4:0]  wb_wreg_addr,
    output logic [31:0] wb_wreg_data,
    output logic        wb_valid,
    output logic        llbit,
    output logic        sc_ok
);
    localparam logic [2:0] OP_LB = 3'd1, OP_LBU = 3'd2, OP_LH = 3'd3, OP_LHU = 3'd4,
                           OP_LW = 3'd5, OP_LL = 3'd6, OP_SC = 3'd7;

    logic        valid_q, valid_d, wen_q, wen_d, llbit_q, llbit_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d, load_data, byte_word;
    logic [1:0]  byte_lane;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        // Big-endian puts offset 0 in the top byte, so the lane index is mirrored
        byte_lane = BIG_ENDIAN ? ~mem_addr_lo : mem_addr_lo;
        byte_word = mem_rdata >> {byte_lane, 3'b000};
        byte_v    = byte_word[7:0];
        half_v    = (BIG_ENDIAN ? ~mem_addr_lo[1] : mem_addr_lo[1]) ? mem_rdata[31:16] : mem_rdata[15:0];
        case (mem_load_op)
            OP_LB:        load_data = {{24{byte_v[7]}}, byte_v};
            OP_LBU:       load_data = {24'b0, byte_v};
            OP_LH:        load_data = {{16{half_v[15]}}, half_v};
            OP_LHU:       load_data = {16'b0, half_v};
            OP_LW, OP_LL: load_data = mem_rdata;
            OP_SC:        load_data = {31'b0, llbit_q};
            default:      load_data = mem_wdata;
        endcase
        valid_d = valid_q;
        wen_d   = wen_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        llbit_d = llbit_q;
        if (flush) begin
            valid_d = 1'b0;
            wen_d   = 1'b0;
            waddr_d = 5'd0;
            wdata_d = 32'd0;
            llbit_d = 1'b0;
        end else if (llbit_clear) begin
            llbit_d = 1'b0;
        end else if (!stall && mem_valid) begin
            llbit_d = (mem_load_op == OP_SC) ? 1'b0 : (mem_load_op == OP_LL) ? 1'b1 : llbit_q;
        end
        if (!flush && !stall) begin
            valid_d = mem_valid;
            wen_d   = mem_valid & mem_wreg_en & (mem_wreg_addr != 5'd0);
            waddr_d = mem_wreg_addr;
            wdata_d = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
            llbit_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            llbit_q <= llbit_d;
        end
    end

    assign wb_valid     = valid_q;
    assign wb_wreg_en   = wen_q;
    assign wb_wreg_addr = waddr_q;
    assign wb_wreg_data = wdata_q;
    assign llbit        = llbit_q;
    assign sc_ok        = mem_valid & ~flush & (mem_load_op == OP_SC) & llbit_q;
endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: directed self-checking bench for mem_wb (big-endian lanes).
module tb_mem_wb;
    logic        clk = 1'b0, rst, mem_valid, mem_wreg_en, stall, flush, llbit_clear;
    logic [4:0]  mem_wreg_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [2:0]  mem_load_op;
    logic [1:0]  mem_addr_lo;
    logic        wb_wreg_en, wb_valid, llbit, sc_ok;
    logic [4:0]  wb_wreg_addr;
    logic [31:0] wb_wreg_data;
    int checks = 0, errors = 0;

    mem_wb #(.BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_wreg_en(mem_wreg_en),
        .mem_wreg_addr(mem_wreg_addr), .mem_wdata(mem_wdata), .mem_load_op(mem_load_op),
        .mem_addr_lo(mem_addr_lo), .mem_rdata(mem_rdata), .stall(stall), .flush(flush),
        .llbit_clear(llbit_clear), .wb_wreg_en(wb_wreg_en), .wb_wreg_addr(wb_wreg_addr),
        .wb_wreg_data(wb_wreg_data), .wb_valid(wb_valid), .llbit(llbit), .sc_ok(sc_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic v, input logic [4:0] a, input logic [2:0] o,
                      input logic [1:0] lo, input logic [31:0] rd, input logic [31:0] wd);
        mem_valid = v; mem_wreg_en = 1'b1; mem_wreg_addr = a; mem_load_op = o;
        mem_addr_lo = lo; mem_rdata = rd; mem_wdata = wd;
    endtask

    task automatic chk_wb(input string tag, input logic v, input logic en,
                          input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".valid"}, 32'(wb_valid), 32'(v));
        chk({tag, ".en"}, 32'(wb_wreg_en), 32'(en));
        chk({tag, ".addr"}, 32'(wb_wreg_addr), 32'(a));
        chk({tag, ".data"}, wb_wreg_data, d);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0; llbit_clear = 1'b0;
        op(1'b1, 5'd7, 3'd0, 2'd0, 32'h0, 32'h5A5A5A5A);
        #3;
        chk_wb("reset", 1'b0, 1'b0, 5'd0, 32'h0);
        chk("reset.llbit", 32'(llbit), 32'h0);
        tick();
        chk_wb("reset_held", 1'b0, 1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        op(1'b1, 5'd3, 3'd1, 2'd1, 32'h12F45678, 32'h0); tick();
        chk_wb("lb", 1'b1, 1'b1, 5'd3, 32'hFFFFFFF4);
        op(1'b1, 5'd3, 3'd2, 2'd1, 32'h12F45678, 32'h0); tick();
        chk("lbu", wb_wreg_data, 32'h000000F4);
        op(1'b1, 5'd4, 3'd1, 2'd0, 32'h12F45678, 32'h0); tick();
        chk("lb_off0", wb_wreg_data, 32'h00000012);
        op(1'b1, 5'd4, 3'd3, 2'd2, 32'h12348001, 32'h0); tick();
        chk("lh_a2", wb_wreg_data, 32'hFFFF8001);
        op(1'b1, 5'd4, 3'd3, 2'd3, 32'h12348001, 32'h0); tick();
        chk("lh_a3", wb_wreg_data, 32'hFFFF8001);
        op(1'b1, 5'd4, 3'd4, 2'd0, 32'h12348001, 32'h0); tick();
        chk("lhu_a0", wb_wreg_data, 32'h00001234);
        op(1'b1, 5'd4, 3'd5, 2'd3, 32'h89ABCDEF, 32'h0); tick();
        chk("lw", wb_wreg_data, 32'h89ABCDEF);
        op(1'b1, 5'd4, 3'd0, 2'd0, 32'h89ABCDEF, 32'h0BADF00D); tick();
        chk("alu", wb_wreg_data, 32'h0BADF00D);
        chk("alu.llbit", 32'(llbit), 32'h0);
        op(1'b1, 5'd8, 3'd6, 2'd0, 32'hCAFE0000, 32'h0); tick();
        chk_wb("ll", 1'b1, 1'b1, 5'd8, 32'hCAFE0000);
        chk("ll.llbit", 32'(llbit), 32'h1);
        op(1'b1, 5'd9, 3'd7, 2'd0, 32'h0, 32'h0); #1;
        chk("sc1.sc_ok", 32'(sc_ok), 32'h1);
        tick();
        chk_wb("sc1", 1'b1, 1'b1, 5'd9, 32'h1);
        chk("sc1.llbit", 32'(llbit), 32'h0);
        chk("sc2.sc_ok", 32'(sc_ok), 32'h0);
        tick();
        chk("sc2", wb_wreg_data, 32'h0);
        op(1'b1, 5'd8, 3'd6, 2'd0, 32'h1, 32'h0); tick();
        chk("ll2.llbit", 32'(llbit), 32'h1);
        op(1'b1, 5'd2, 3'd0, 2'd0, 32'h0, 32'h77777777); flush = 1'b1; tick();
        flush = 1'b0;
        chk_wb("flush", 1'b0, 1'b0, 5'd0, 32'h0);
        chk("flush.llbit", 32'(llbit), 32'h0);
        op(1'b1, 5'd9, 3'd7, 2'd0, 32'h0, 32'h0); #1;
        chk("sc_after_flush.sc_ok", 32'(sc_ok), 32'h0);
        tick();
        chk("sc_after_flush", wb_wreg_data, 32'h0);
        op(1'b1, 5'd8, 3'd6, 2'd0, 32'h1, 32'h0); tick();
        op(1'b1, 5'd9, 3'd7, 2'd0, 32'h0, 32'h0); flush = 1'b1; stall = 1'b1; #1;
        chk("flush_sc.sc_ok", 32'(sc_ok), 32'h0);
        tick();
        flush = 1'b0; stall = 1'b0;
        chk_wb("flush_stall", 1'b0, 1'b0, 5'd0, 32'h0);
        chk("flush_stall.llbit", 32'(llbit), 32'h0);
        op(1'b1, 5'd0, 3'd0, 2'd0, 32'h0, 32'hDEADBEEF); tick();
        chk_wb("zero_dst", 1'b1, 1'b0, 5'd0, 32'hDEADBEEF);
        op(1'b1, 5'd5, 3'd0, 2'd0, 32'h0, 32'h11111111); tick();
        op(1'b1, 5'd6, 3'd6, 2'd0, 32'h22222222, 32'h0); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_wb($sformatf("stall%0d", i), 1'b1, 1'b1, 5'd5, 32'h11111111);
            chk($sformatf("stall%0d.llbit", i), 32'(llbit), 32'h0);
        end
        stall = 1'b0;
        op(1'b0, 5'd6, 3'd6, 2'd0, 32'h22222222, 32'h0); tick();
        chk("invalid.valid", 32'(wb_valid), 32'h0);
        chk("invalid.en", 32'(wb_wreg_en), 32'h0);
        chk("invalid.llbit", 32'(llbit), 32'h0);
        op(1'b1, 5'd6, 3'd6, 2'd0, 32'h1, 32'h0); tick();
        chk("ll3.llbit", 32'(llbit), 32'h1);
        op(1'b0, 5'd6, 3'd7, 2'd0, 32'h0, 32'h0); #1;
        chk("invalid_sc.sc_ok", 32'(sc_ok), 32'h0);
        tick();
        chk("invalid_sc.llbit", 32'(llbit), 32'h1);
        op(1'b1, 5'd6, 3'd0, 2'd0, 32'h0, 32'h0); llbit_clear = 1'b1; stall = 1'b1; tick();
        llbit_clear = 1'b0; stall = 1'b0;
        chk("llclear.llbit", 32'(llbit), 32'h0);
        op(1'b1, 5'd4, 3'd0, 2'd0, 32'h0, 32'hAAAA5555); tick();
        chk_wb("pre_areset", 1'b1, 1'b1, 5'd4, 32'hAAAA5555);
        #2 rst = 1'b0;
        #1;
        chk_wb("areset", 1'b0, 1'b0, 5'd0, 32'h0);
        stall = 1'b1; tick();
        chk_wb("areset_held", 1'b0, 1'b0, 5'd0, 32'h0);
        stall = 1'b0; rst = 1'b1;
        op(1'b1, 5'd10, 3'd0, 2'd0, 32'h0, 32'h00C0FFEE); tick();
        chk_wb("post_reset", 1'b1, 1'b1, 5'd10, 32'h00C0FFEE);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_wb.md
MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 Parameter: BIG_ENDIAN, default 1, byte lane order; 1 = address offset 0 is bits 31:24, 0 = offset 0 is bits 7:0.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low (0 = RST_ENABLE).
REQ-004 mem_valid  in  1  MEM stage holds a real instruction.
REQ-005 mem_wreg_en  in  1  instruction writes a GPR.
REQ-006 mem_wreg_addr  in  5  destination GPR index.
REQ-007 mem_wdata  in  32  ALU/move result for non-load ops.
REQ-008 mem_load_op  in  3  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LL, 7 SC.
REQ-009 mem_addr_lo  in  2  effective address bits 1:0.
REQ-010 mem_rdata  in  32  data-memory read word, valid in the same cycle as the MEM instruction.
REQ-011 stall  in  1  hold the WB register.
REQ-012 flush  in  1  kill the MEM instruction and clear the link bit (exception/redirect).
REQ-013 llbit_clear  in  1  ERET-driven link-bit clear.
REQ-014 wb_wreg_en, wb_wreg_addr, wb_wreg_data  out  1/5/32  registered write port driven into the register file.
REQ-015 wb_valid  out  1  WB register holds a real instruction.
REQ-016 llbit  out  1  current link bit, registered.
REQ-017 sc_ok  out  1  combinational; 1 when mem_load_op=SC and llbit=1, so memory may commit the store.

Function
REQ-018 Capture: on a rising edge with rst=1, flush=0 and stall=0, all wb_* outputs SHALL load from MEM inputs; latency is exactly 1 cycle.
REQ-019 Stall: stall=1 with flush=0 SHALL hold every wb_* output and llbit unchanged.
REQ-020 Flush: flush=1 SHALL load a bubble (wb_valid=0, wb_wreg_en=0, wb_wreg_addr=0, wb_wreg_data=0) regardless of stall; flush beats stall.
REQ-021 wb_wreg_en SHALL be captured as mem_valid & mem_wreg_en & (mem_wreg_addr!=0); a write to $0 is suppressed here.
REQ-022 Lane select: byte lane k = mem_addr_lo (mirrored per BIG_ENDIAN); halfword lane = mem_addr_lo[1]; mem_addr_lo[0] is ignored for LH/LHU and both bits for LW/LL (alignment is checked upstream).
REQ-023 LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend the selected lane to 32 bits; LW and LL SHALL pass mem_rdata unchanged; NONE SHALL pass mem_wdata.
REQ-024 SC SHALL write {31'b0, llbit} using llbit as it was before the same edge.
REQ-025 Link bit next state, priority high to low: flush -> 0; llbit_clear -> 0; stall -> hold; captured valid SC -> 0; captured valid LL -> 1; otherwise hold.
REQ-026 A non-valid instruction (mem_valid=0) SHALL load wb_valid=0 and wb_wreg_en=0, and SHALL NOT change llbit.
REQ-027 sc_ok SHALL be 0 when mem_valid=0 or flush=1.

Reset
REQ-028 rst=0 SHALL asynchronously force wb_valid=0, wb_wreg_en=0, wb_wreg_addr=0, wb_wreg_data=0 and llbit=0, and hold them while low, including mid-stall.
REQ-029 After rst deasserts, the first capture occurs on the next qualifying rising edge; no input is sampled while rst=0.

Verification
REQ-030 BIG_ENDIAN=1, LB with mem_rdata=32'h12F45678, addr_lo=1 -> next cycle wb_wreg_data=32'hFFFFFFF4; LBU same inputs -> 32'h000000F4.
REQ-031 LH, mem_rdata=32'h1234_8001, addr_lo=2 -> 32'hFFFF8001; addr_lo=3 gives the same result; LHU addr_lo=0 -> 32'h00001234.
REQ-032 LL to $8 then SC to $9 with no intervening clear -> $9 data=1, sc_ok=1 during the SC cycle, llbit=0 afterwards; repeating the SC -> data=0, sc_ok=0.
REQ-033 LL, then flush pulse, then SC -> llbit=0 after the flush and SC writes 0; stall=1 together with flush=1 -> bubble loaded and llbit=0.
REQ-034 ALU op mem_wdata=32'hDEADBEEF to addr 0 -> wb_wreg_en=0, wb_valid=1; 3-cycle stall -> outputs frozen for 3 cycles.
REQ-035 Assert rst=0 asynchronously between clock edges while wb holds a valid write -> all outputs 0 immediately, before the next edge.
